// File: rtl/ahb_gpio_irq_pkg.sv
// Shared definitions for the AHB-Lite GPIO peripheral: register offsets,
// HTRANS encodings, bus-side state encoding and the parity helper.
package gpio_pkg;

    localparam int MAX_WIDTH = 31;

    typedef enum logic [2:0] {
        REG_DATA_OUT    = 3'd0,
        REG_DIR         = 3'd1,
        REG_DATA_IN     = 3'd2,
        REG_IRQ_RISE_EN = 3'd3,
        REG_IRQ_FALL_EN = 3'd4,
        REG_IRQ_STATUS  = 3'd5
    } reg_off_e;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_DATA = 1'b1
    } bus_state_e;

    // Parity of a zero-extended data word; odd_sel=1 selects odd parity.
    function automatic logic parity_bit(input logic [MAX_WIDTH-1:0] data, input logic odd_sel);
        parity_bit = (^data) ^ odd_sel;
    endfunction

endpackage

// File: rtl/ahb_gpio_irq_if.sv
// AHB-Lite slave-side signal bundle used between the bus fabric and the GPIO block.
interface ahb_gpio_irq_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA
    );

endinterface

// File: rtl/ahb_gpio_irq_sync_edge.sv
// Input synchroniser chain for the GPIO pads plus edge history and
// enable-qualified rise/fall event vectors.
module gpio_sync_edge #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] pad_i,
    input  logic [WIDTH-1:0] rise_en_i,
    input  logic [WIDTH-1:0] fall_en_i,
    output logic [WIDTH-1:0] data_in_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_q;

    // Synchroniser shift chain and one-cycle history of the synchronised value.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= {(SYNC_STAGES*WIDTH){1'b0}};
            prev_q <= {WIDTH{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign data_in_o = sync_q[SYNC_STAGES-1];
    assign rise_o    = data_in_o & ~prev_q & rise_en_i;
    assign fall_o    = ~data_in_o & prev_q & fall_en_i;

endmodule

// File: rtl/ahb_gpio_irq.sv
// Zero-wait-state AHB-Lite GPIO slave with direction control, synchronised
// inputs, rise/fall edge interrupts (W1C status) and parity-checked output writes.
module ahb_gpio_irq
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int PARITY_EN   = 1
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahb_gpio_irq_if.slave      bus,
    input  logic               PARITYSEL,
    output logic               PARITYERR,
    input  logic [WIDTH-1:0]   GPIOIN,
    output logic [WIDTH-1:0]   GPIOOUT,
    output logic [WIDTH-1:0]   GPIOEN,
    output logic               GPIOIRQ
);

    localparam logic PARITY_ON = (PARITY_EN != 0);

    bus_state_e       state_q, state_d;
    logic             valid_s;
    logic             accept_s;
    logic             hwrite_q;
    reg_off_e         addr_q;

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic             parityerr_q, parityerr_d;

    logic [WIDTH-1:0] wdata_s;
    logic [WIDTH-1:0] clr_s;
    logic             wr_en_s;
    logic             parity_bad_s;
    logic [31:0]      rdata_s;
    logic [WIDTH-1:0] data_in_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic             unused_s;

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i     (HCLK),
        .rst_ni    (HRESETn),
        .pad_i     (GPIOIN),
        .rise_en_i (rise_en_q),
        .fall_en_i (fall_en_q),
        .data_in_o (data_in_s),
        .rise_o    (rise_s),
        .fall_o    (fall_s)
    );

    assign accept_s = bus.HSEL & bus.HREADY & bus.HTRANS[1];

    // Bus-side state register: IDLE or DATA (data phase pending).
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= BUS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every accepted address phase leads into a data phase.
    always_comb begin
        state_d = BUS_IDLE;
        case (state_q)
            BUS_IDLE: state_d = accept_s ? BUS_DATA : BUS_IDLE;
            BUS_DATA: state_d = accept_s ? BUS_DATA : BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    // State outputs: the data phase is valid only in DATA.
    always_comb begin
        valid_s = 1'b0;
        if (state_q == BUS_DATA) begin
            valid_s = 1'b1;
        end else begin
            valid_s = 1'b0;
        end
    end

    // Address-phase capture of direction and register offset.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            hwrite_q <= 1'b0;
            addr_q   <= REG_DATA_OUT;
        end else if (accept_s) begin
            hwrite_q <= bus.HWRITE;
            addr_q   <= reg_off_e'(bus.HADDR[4:2]);
        end
    end

    assign wr_en_s      = valid_s & hwrite_q;
    assign wdata_s      = bus.HWDATA[WIDTH-1:0];
    assign parity_bad_s = PARITY_ON &&
                          (bus.HWDATA[WIDTH] != parity_bit(MAX_WIDTH'(wdata_s), PARITYSEL));

    // Write decode: next values for the RW registers, the W1C mask and the parity flag.
    always_comb begin
        data_out_d  = data_out_q;
        dir_d       = dir_q;
        rise_en_d   = rise_en_q;
        fall_en_d   = fall_en_q;
        clr_s       = {WIDTH{1'b0}};
        parityerr_d = 1'b0;
        if (wr_en_s) begin
            case (addr_q)
                REG_DATA_OUT: begin
                    if (parity_bad_s) begin
                        parityerr_d = 1'b1;
                    end else begin
                        data_out_d = wdata_s;
                    end
                end
                REG_DIR:         dir_d     = wdata_s;
                REG_IRQ_RISE_EN: rise_en_d = wdata_s;
                REG_IRQ_FALL_EN: fall_en_d = wdata_s;
                REG_IRQ_STATUS:  clr_s     = wdata_s;
                default:         clr_s     = {WIDTH{1'b0}};
            endcase
        end else begin
            parityerr_d = 1'b0;
        end
    end

    // A new edge in the same cycle as a clear keeps the bit set.
    assign status_d = (status_q & ~clr_s) | rise_s | fall_s;

    // Register file and parity-error pulse.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            data_out_q  <= {WIDTH{1'b0}};
            dir_q       <= {WIDTH{1'b0}};
            rise_en_q   <= {WIDTH{1'b0}};
            fall_en_q   <= {WIDTH{1'b0}};
            status_q    <= {WIDTH{1'b0}};
            parityerr_q <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            dir_q       <= dir_d;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            status_q    <= status_d;
            parityerr_q <= parityerr_d;
        end
    end

    // Read mux for the data phase of a read; zero otherwise.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (valid_s && !hwrite_q) begin
            case (addr_q)
                REG_DATA_OUT:    rdata_s[WIDTH-1:0] = data_out_q;
                REG_DIR:         rdata_s[WIDTH-1:0] = dir_q;
                REG_DATA_IN: begin
                    rdata_s[WIDTH-1:0] = data_in_s;
                    rdata_s[WIDTH]     = parity_bit(MAX_WIDTH'(data_in_s), PARITYSEL);
                end
                REG_IRQ_RISE_EN: rdata_s[WIDTH-1:0] = rise_en_q;
                REG_IRQ_FALL_EN: rdata_s[WIDTH-1:0] = fall_en_q;
                REG_IRQ_STATUS:  rdata_s[WIDTH-1:0] = status_q;
                default:         rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign bus.HRDATA    = rdata_s;
    assign bus.HREADYOUT = 1'b1;
    assign PARITYERR     = parityerr_q;
    assign GPIOOUT       = data_out_q;
    assign GPIOEN        = dir_q;
    assign GPIOIRQ       = |status_q;

    assign unused_s = ^{bus.HADDR, bus.HTRANS[0], bus.HWDATA};

endmodule
